// File: rtl/otter_pipe_pkg.sv
// Shared pipeline constants for the Otter: forwarding-source encodings,
// the default forwarding depth and the standard result latencies.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_src_e;

  localparam int FWD_STAGES_DEF = 3;
  localparam int LAT_ALU        = 1;
  localparam int LAT_LOAD       = 3;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks whether a register has an in-flight write,
// how far down the pipe it has travelled (age) and when its result appears (lat).
module sb_entry
  import otter_pipe_pkg::*;
#(
  parameter int FWD_STAGES = FWD_STAGES_DEF,
  parameter int LAT_W      = 2,
  parameter int AGE_W      = 3,
  parameter int FLUSH_AGE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  input  logic             squash,
  output logic             pend,
  output logic [AGE_W-1:0] age,
  output logic [LAT_W-1:0] lat
);

  // NOTE: state registers use non-blocking assignments so every entry samples
  // the pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      age  <= '0;
      lat  <= '0;
    end else if (set) begin
      // A new producer overwrites any older one, so the youngest write wins.
      pend <= 1'b1;
      age  <= AGE_W'(1);
      lat  <= set_lat;
    end else if (pend) begin
      // Squash young entries on flush; retire once the value reaches the register file.
      if ((squash && int'(age) < FLUSH_AGE) || int'(age) >= FWD_STAGES) begin
        pend <= 1'b0;
        age  <= '0;
        lat  <= '0;
      end else begin
        age <= age + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-side scoreboard: generates stall, issue and per-operand forward selects
// from a per-register record of in-flight writes, for any forwarding depth.
module scoreboard_hazard_unit
  import otter_pipe_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int FWD_STAGES = FWD_STAGES_DEF,
  parameter int LAT_W      = 2,
  parameter int FLUSH_AGE  = 1,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_rd_wen,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [SEL_W-1:0] fwd_sel_rs1,
  output logic [SEL_W-1:0] fwd_sel_rs2,
  output logic [NREG-1:0]  pending_mask,
  output logic [31:0]      stall_cycles
);

  localparam int AGE_W = $clog2(FWD_STAGES + 2);

  typedef struct packed {
    logic             hazard;
    logic [SEL_W-1:0] sel;
  } op_chk_t;

  logic [NREG-1:0]  pend_vec;
  logic [AGE_W-1:0] age_arr [NREG];
  logic [LAT_W-1:0] lat_arr [NREG];
  logic [LAT_W-1:0] eff_lat;
  op_chk_t          chk_rs1;
  op_chk_t          chk_rs2;

  // Not yet valid at this age -> stall; otherwise forward from the stage it has reached.
  function automatic op_chk_t check_operand(input logic             used,
                                            input logic [AW-1:0]    addr,
                                            input logic             pend,
                                            input logic [AGE_W-1:0] age,
                                            input logic [LAT_W-1:0] lat);
    op_chk_t r;
    r.hazard = 1'b0;
    r.sel    = SEL_W'(FWD_RF);
    if (used && addr != '0 && pend) begin
      if (int'(age) < int'(lat)) r.hazard = 1'b1;
      else                       r.sel    = SEL_W'(age);
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_lat = id_lat;
    if (id_lat == '0)                     eff_lat = LAT_W'(1);
    else if (int'(id_lat) > FWD_STAGES)   eff_lat = LAT_W'(FWD_STAGES);
  end

  always_comb begin
    chk_rs1 = check_operand(id_rs1_used, id_rs1, pend_vec[id_rs1], age_arr[id_rs1], lat_arr[id_rs1]);
    chk_rs2 = check_operand(id_rs2_used, id_rs2, pend_vec[id_rs2], age_arr[id_rs2], lat_arr[id_rs2]);
  end

  assign stall        = id_valid & (chk_rs1.hazard | chk_rs2.hazard) & ~flush;
  assign issue        = id_valid & ~stall & ~flush;
  assign fwd_sel_rs1  = chk_rs1.sel;
  assign fwd_sel_rs2  = chk_rs2.sel;
  assign pending_mask = pend_vec;

  // Register 0 is hardwired zero and never has an in-flight write.
  assign pend_vec[0] = 1'b0;
  assign age_arr[0]  = '0;
  assign lat_arr[0]  = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic set_r;
    assign set_r = issue & id_rd_wen & (id_rd == AW'(r));

    sb_entry #(
      .FWD_STAGES (FWD_STAGES),
      .LAT_W      (LAT_W),
      .AGE_W      (AGE_W),
      .FLUSH_AGE  (FLUSH_AGE)
    ) u_entry (
      .clk     (clk),
      .rst_n   (RESET_N),
      .set     (set_r),
      .set_lat (eff_lat),
      .squash  (flush),
      .pend    (pend_vec[r]),
      .age     (age_arr[r]),
      .lat     (lat_arr[r])
    );
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N)                        stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule
